led_pattern_gen: RTL

Multi-channel LED driver and parametrised successor of the single 1 s blinker. One shared millisecond-tick prescaler drives N_LED independent channels. Each channel runs its own mode (OFF, ON, BLINK, BREATHE) and period, and is reprogrammed at run time through a valid/ready config port. Sits between board LED pins and any control logic (key debouncer, UART command decoder).

---
 rtl/led_pattern_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared tick prescaler, per-channel OFF/ON/BLINK/BREATHE with run-time
// config. Define LED_BREATHE_EN to build the PWM breathe engine; otherwise BREATHE acts as ON.
module led_pattern_gen #(
   parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
   parameter int unsigned TICK_HZ        = 1000,
   parameter int unsigned N_LED          = 4,
   parameter int unsigned PWM_BITS       = 8,
   parameter int unsigned DEFAULT_PERIOD = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [3:0]       cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [15:0]      cfg_period,
   output logic             cfg_err,
   output logic             tick,
   output logic [N_LED-1:0] led_out
);

   localparam int unsigned DIV      = CLK_FREQ_HZ / TICK_HZ;
   localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

   typedef enum logic [1:0] {
      ModeOff     = 2'b00,
      ModeOn      = 2'b01,
      ModeBlink   = 2'b10,
      ModeBreathe = 2'b11
   } mode_e;

   logic             ready_q;
   logic [31:0]      presc_q, presc_d;
   logic             err_q, err_d;
   logic             wr, ch_ok;

   mode_e            mode_q   [N_LED];
   mode_e            mode_d   [N_LED];
   logic [15:0]      period_q [N_LED];
   logic [15:0]      period_d [N_LED];
   logic [15:0]      cnt_q    [N_LED];
   logic [15:0]      cnt_d    [N_LED];
   logic [15:0]      last     [N_LED];
   logic [N_LED-1:0] expire;
   logic [N_LED-1:0] state_q, state_d;
   logic [N_LED-1:0] led_q, led_d;

`ifdef LED_BREATHE_EN
   localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

   logic [PWM_BITS-1:0] pwm_q;
   logic [PWM_BITS-1:0] duty_q [N_LED];
   logic [PWM_BITS-1:0] duty_d [N_LED];
   logic [N_LED-1:0]    dir_q, dir_d;  // 1 = counting up
`endif

   // Everything downstream waits for cfg_ready so the time base starts cleanly after reset.
   always_comb begin
      tick    = ready_q && (presc_q == DIV_LAST);
      presc_d = presc_q;
      if (ready_q) begin
         presc_d = tick ? '0 : presc_q + 32'd1;
      end
      wr    = cfg_valid && ready_q;
      ch_ok = {1'b0, cfg_ch} < 5'(N_LED);
      err_d = wr && !ch_ok;
   end

   always_comb begin
      for (int i = 0; i < N_LED; i++) begin
         mode_d[i]   = mode_q[i];
         period_d[i] = period_q[i];
         cnt_d[i]    = cnt_q[i];
         state_d[i]  = state_q[i];
         led_d[i]    = led_q[i];
`ifdef LED_BREATHE_EN
         duty_d[i]   = duty_q[i];
         dir_d[i]    = dir_q[i];
`endif
         // A zero period behaves as one tick.
         last[i]   = (period_q[i] == 16'd0) ? 16'd0 : period_q[i] - 16'd1;
         expire[i] = tick && (cnt_q[i] == last[i]);

         unique case (mode_q[i])
            ModeOff: begin
               cnt_d[i] = '0;
               led_d[i] = 1'b0;
            end
            ModeOn: begin
               cnt_d[i] = '0;
               led_d[i] = 1'b1;
            end
            ModeBlink: begin
               if (expire[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ~state_q[i];
               end else if (tick) begin
                  cnt_d[i] = cnt_q[i] + 16'd1;
               end
               led_d[i] = state_d[i];
            end
            ModeBreathe: begin
`ifdef LED_BREATHE_EN
               if (expire[i]) begin
                  cnt_d[i] = '0;
                  if (dir_q[i]) begin
                     duty_d[i] = duty_q[i] + 1'b1;
                     if (duty_d[i] == DUTY_MAX) dir_d[i] = 1'b0;
                  end else begin
                     duty_d[i] = duty_q[i] - 1'b1;
                     if (duty_d[i] == '0) dir_d[i] = 1'b1;
                  end
               end else if (tick) begin
                  cnt_d[i] = cnt_q[i] + 16'd1;
               end
               led_d[i] = (pwm_q < duty_q[i]);
`else
               cnt_d[i] = '0;
               led_d[i] = 1'b1;
`endif
            end
            default: begin
               cnt_d[i] = '0;
               led_d[i] = 1'b0;
            end
         endcase

         // A config write overrides any expiry landing on the same cycle.
         if (wr && ch_ok && (cfg_ch == 4'(i))) begin
            mode_d[i]   = mode_e'(cfg_mode);
            period_d[i] = cfg_period;
            cnt_d[i]    = '0;
            state_d[i]  = 1'b0;
`ifdef LED_BREATHE_EN
            duty_d[i]   = '0;
            dir_d[i]    = 1'b1;
            led_d[i]    = (cfg_mode == ModeOn);
`else
            led_d[i]    = (cfg_mode == ModeOn) || (cfg_mode == ModeBreathe);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q  <= 1'b0;
         presc_q  <= '0;
         err_q    <= 1'b0;
         mode_q   <= '{default: ModeBlink};
         period_q <= '{default: 16'(DEFAULT_PERIOD)};
         cnt_q    <= '{default: 16'd0};
         state_q  <= '0;
         led_q    <= '0;
`ifdef LED_BREATHE_EN
         pwm_q    <= '0;
         duty_q   <= '{default: '0};
         dir_q    <= '1;
`endif
      end else begin
         ready_q  <= 1'b1;
         presc_q  <= presc_d;
         err_q    <= err_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         led_q    <= led_d;
`ifdef LED_BREATHE_EN
         pwm_q    <= pwm_q + 1'b1;
         duty_q   <= duty_d;
         dir_q    <= dir_d;
`endif
      end
   end

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;
   assign led_out   = led_q;

endmodule
